slow_memory_param: RTL and testbench



---
 rtl/slow_memory_param.sv | 170 +++++++++++++++++
 tb/tb_slow_memory_param.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_memory_param.sv
// slow_memory_param
//   Parametrised slow main-memory model serving one cache port. A request
//   (read or write, held by the requester) is sampled in IDLE. Its address,
//   data and operation are latched. The access is performed LATENCY cycles
//   later and is signalled by a one-cycle proc_ready pulse. A sticky prot_err
//   flags these cases:
//     - simultaneous read/write requests;
//     - request changes while the access is pending;
//     - addresses at or beyond DEPTH.
//   Saturating counters track completed reads and writes.
//   The mem array has no reset, so a preload survives reset.
//
// Parameters
//   LINE_W   bits per line
//   ADDR_W   line-address width
//   DEPTH    implemented lines, mem[0:DEPTH-1]
//   LATENCY  request sample to proc_ready, legal range 1..255
//   CNT_W    access counter width
//
// Ports
//   clk         clock, rising-edge
//   rst         asynchronous active-high reset
//   proc_read   read request, held until proc_ready
//   proc_write  write request, held until proc_ready
//   proc_addr   line address
//   proc_wdata  write line
//   proc_rdata  last completed read line (zero for out-of-range reads)
//   proc_ready  one-cycle completion pulse
//   prot_err    sticky protocol/range error
//   rd_count    completed reads, saturating
//   wr_count    completed writes, saturating
module slow_memory_param #(
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [LINE_W-1:0] proc_wdata,
    output logic [LINE_W-1:0] proc_rdata,
    output logic              proc_ready,
    output logic              prot_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              lat_write;

    logic              start;     // single valid request accepted in IDLE
    logic              both_err;  // read and write together in IDLE
    logic              dec;       // latency countdown still running
    logic              access;    // last WAIT cycle: perform the access
    logic              viol;      // request altered while pending
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic [LINE_W-1:0] mem [0:DEPTH-1];

    assign in_range = (lat_addr < ADDR_W'(DEPTH));
    assign idx      = lat_addr[IDX_W-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (proc_read ^ proc_write) next_state = WAIT;
            WAIT: if (cnt == '0) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        proc_ready = 1'b0;
        start      = 1'b0;
        both_err   = 1'b0;
        dec        = 1'b0;
        access     = 1'b0;
        viol       = 1'b0;
        unique case (state)
            IDLE: begin
                start    = proc_read ^ proc_write;
                both_err = proc_read & proc_write;
            end
            WAIT: begin
                dec    = (cnt != '0);
                access = (cnt == '0);
                // Held request must match the latched one exactly.
                viol   = (proc_read != ~lat_write) || (proc_write != lat_write) ||
                         (proc_addr != lat_addr);
            end
            RESP: proc_ready = 1'b1;
            default: ;
        endcase
    end

    // Request latch, countdown, read data, error flag and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
            proc_rdata <= '0;
            prot_err   <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            if (start) begin
                lat_addr  <= proc_addr;
                lat_wdata <= proc_wdata;
                lat_write <= proc_write;
                cnt       <= CNT_INIT;
            end else if (dec) begin
                cnt <= cnt - 8'd1;
            end

            if (both_err || viol || (access && !in_range)) begin
                prot_err <= 1'b1;
            end

            if (access) begin
                if (lat_write) begin
                    if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
                end else begin
                    proc_rdata <= in_range ? mem[idx] : '0;
                    if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
                end
            end
        end
    end

    // Storage: no reset. A reset mid-transaction forces IDLE, so no write lands.
    always_ff @(posedge clk) begin
        if (access && lat_write && in_range) begin
            mem[idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_slow_memory_param.sv
module tb_slow_memory_param;

    localparam int unsigned A_LAT   = 8;
    localparam int unsigned A_DEPTH = 4096;
    localparam int unsigned A_CNT   = 16;
    localparam int unsigned B_LAT   = 1;
    localparam int unsigned B_DEPTH = 16;
    localparam int unsigned B_CNT   = 8;
    localparam int unsigned B_LINE  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: default geometry
    logic         a_read, a_write;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic         a_ready, a_err;
    logic [15:0]  a_rdc, a_wrc;

    // Instance B: LATENCY=1, small counters for saturation
    logic              b_read, b_write;
    logic [27:0]       b_addr;
    logic [B_LINE-1:0] b_wdata, b_rdata;
    logic              b_ready, b_err;
    logic [B_CNT-1:0]  b_rdc, b_wrc;

    slow_memory_param dut_a (
        .clk(clk), .rst(rst), .proc_read(a_read), .proc_write(a_write),
        .proc_addr(a_addr), .proc_wdata(a_wdata), .proc_rdata(a_rdata),
        .proc_ready(a_ready), .prot_err(a_err), .rd_count(a_rdc), .wr_count(a_wrc)
    );

    slow_memory_param #(
        .LINE_W(B_LINE), .ADDR_W(28), .DEPTH(B_DEPTH), .LATENCY(B_LAT), .CNT_W(B_CNT)
    ) dut_b (
        .clk(clk), .rst(rst), .proc_read(b_read), .proc_write(b_write),
        .proc_addr(b_addr), .proc_wdata(b_wdata), .proc_rdata(b_rdata),
        .proc_ready(b_ready), .prot_err(b_err), .rd_count(b_rdc), .wr_count(b_wrc)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] ref_mem [int];
    logic [127:0] pat_a5;

    // Called at a negedge; returns at a negedge one cycle after the ready pulse.
    // lat = clock edges from the sampling edge to the edge raising proc_ready.
    task automatic a_access(input bit is_write, input logic [27:0] addr,
                            input logic [127:0] wdata, output int lat,
                            output logic [127:0] rdata_seen, output logic [127:0] mem_seen,
                            output logic ready_after);
        logic [11:0] idx;
        a_read  = ~is_write;
        a_write = is_write;
        a_addr  = addr;
        a_wdata = wdata;
        lat = -1;
        mem_seen = '0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (a_ready === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        rdata_seen = a_rdata;
        idx = addr[11:0];
        if (addr < A_DEPTH) mem_seen = dut_a.mem[idx];
        a_read  = 1'b0;
        a_write = 1'b0;
        @(negedge clk);
        ready_after = a_ready;
    endtask

    task automatic do_reset();
        a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int lat;
        logic [127:0] rd, ms;
        logic ra;
        int seen;
        do_reset();
        // Build up non-zero state: a completed read and a protocol error.
        a_access(1'b0, 28'd3, '0, lat, rd, ms, ra);
        a_read = 1'b1; a_write = 1'b1;
        @(negedge clk);
        a_read = 1'b0; a_write = 1'b0;
        @(negedge clk);
        // Pending write to addr 5 interrupted by an asynchronous reset.
        a_write = 1'b1; a_addr = 28'd5; a_wdata = 128'hDEAD;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0h expected 0", a_ready); end
        checks++; if (a_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %0h expected 0", a_rdata); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h expected 0", a_err); end
        checks++; if (a_rdc !== '0) begin errors++; $display("FAIL rst_rd_count: got %0h expected 0", a_rdc); end
        checks++; if (a_wrc !== '0) begin errors++; $display("FAIL rst_wr_count: got %0h expected 0", a_wrc); end
        a_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_ready === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_ready: got %0d pulses expected 0", seen); end
        checks++; if (dut_a.mem[5] !== ref_mem[5]) begin errors++; $display("FAIL rst_mem5: got %0h expected %0h", dut_a.mem[5], ref_mem[5]); end
    endtask

    task automatic test_read_latency();
        int lat;
        logic [127:0] rd, ms;
        logic ra;
        do_reset();
        a_access(1'b0, 28'd3, '0, lat, rd, ms, ra);
        checks++; if (lat !== int'(A_LAT)) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, A_LAT); end
        checks++; if (rd !== pat_a5) begin errors++; $display("FAIL rd_data: got %0h expected %0h", rd, pat_a5); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got %0h expected 0", ra); end
        checks++; if (a_rdc !== 16'd1) begin errors++; $display("FAIL rd_count1: got %0h expected 1", a_rdc); end
        checks++; if (a_wrc !== 16'd0) begin errors++; $display("FAIL rd_wr_count0: got %0h expected 0", a_wrc); end
    endtask

    task automatic test_write_read();
        int lat;
        logic [127:0] rd, ms;
        logic ra;
        do_reset();
        a_access(1'b1, 28'd7, 128'h1234, lat, rd, ms, ra);
        ref_mem[7] = 128'h1234;
        checks++; if (lat !== int'(A_LAT)) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, A_LAT); end
        checks++; if (ms !== 128'h1234) begin errors++; $display("FAIL wr_visible: got %0h expected 1234", ms); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL wr_rdata_hold: got %0h expected 0", rd); end
        a_access(1'b0, 28'd7, '0, lat, rd, ms, ra);
        checks++; if (rd !== 128'h1234) begin errors++; $display("FAIL wr_readback: got %0h expected 1234", rd); end
        checks++; if (a_wrc !== 16'd1) begin errors++; $display("FAIL wr_count: got %0h expected 1", a_wrc); end
        checks++; if (a_rdc !== 16'd1) begin errors++; $display("FAIL wr_rd_count: got %0h expected 1", a_rdc); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %0h expected 0", a_err); end
    endtask

    task automatic test_both_error();
        int seen;
        do_reset();
        a_read = 1'b1; a_write = 1'b1; a_addr = 28'd3;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_ready === 1'b1) seen++;
        end
        a_read = 1'b0; a_write = 1'b0;
        @(negedge clk);
        checks++; if (seen !== 0) begin errors++; $display("FAIL both_no_ready: got %0d pulses expected 0", seen); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL both_err: got %0h expected 1", a_err); end
        checks++; if (a_rdc !== 16'd0 || a_wrc !== 16'd0) begin errors++; $display("FAIL both_counts: got %0h/%0h expected 0/0", a_rdc, a_wrc); end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [127:0] rd, ms;
        logic ra;
        do_reset();
        a_access(1'b0, 28'd3, '0, lat, rd, ms, ra);
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL oor_err_before: got %0h expected 0", a_err); end
        a_access(1'b0, 28'(A_DEPTH), '0, lat, rd, ms, ra);
        checks++; if (lat !== int'(A_LAT)) begin errors++; $display("FAIL oor_latency: got %0d expected %0d", lat, A_LAT); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL oor_rdata: got %0h expected 0", rd); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL oor_err: got %0h expected 1", a_err); end
        checks++; if (a_rdc !== 16'd2) begin errors++; $display("FAIL oor_rd_count: got %0h expected 2", a_rdc); end
        a_access(1'b1, 28'(A_DEPTH + 1), {4{32'h0BAD0BAD}}, lat, rd, ms, ra);
        checks++; if (lat !== int'(A_LAT)) begin errors++; $display("FAIL oor_wr_latency: got %0d expected %0d", lat, A_LAT); end
        checks++; if (a_wrc !== 16'd1) begin errors++; $display("FAIL oor_wr_count: got %0h expected 1", a_wrc); end
        checks++; if (dut_a.mem[1] !== ref_mem[1]) begin errors++; $display("FAIL oor_wr_dropped: got %0h expected %0h", dut_a.mem[1], ref_mem[1]); end
    endtask

    task automatic test_mid_op_violation();
        int lat;
        do_reset();
        a_read = 1'b1; a_write = 1'b0; a_addr = 28'd3;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 3) a_addr = 28'd4;
            if (a_ready === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        checks++; if (lat !== int'(A_LAT)) begin errors++; $display("FAIL midop_latency: got %0d expected %0d", lat, A_LAT); end
        checks++; if (a_rdata !== ref_mem[3]) begin errors++; $display("FAIL midop_rdata: got %0h expected %0h", a_rdata, ref_mem[3]); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL midop_err: got %0h expected 1", a_err); end
        checks++; if (a_rdc !== 16'd1) begin errors++; $display("FAIL midop_rd_count: got %0h expected 1", a_rdc); end
        a_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] rd, ms, wd, exp_rdata;
        logic ra;
        logic [27:0] addr;
        bit is_wr;
        int exp_rd, exp_wr, cmax;
        bit exp_err;
        do_reset();
        exp_rdata = '0; exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
        cmax = (1 << A_CNT) - 1;
        for (int t = 0; t < 40; t++) begin
            is_wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) addr = 28'(A_DEPTH + $urandom_range(0, 100));
            else addr = 28'($urandom_range(0, 63));
            wd = {$urandom, $urandom, $urandom, $urandom};
            if (addr >= A_DEPTH) exp_err = 1'b1;
            if (is_wr) begin
                if (addr < A_DEPTH) ref_mem[int'(addr)] = wd;
                exp_wr = (exp_wr < cmax) ? exp_wr + 1 : exp_wr;
            end else begin
                exp_rdata = (addr < A_DEPTH) ? ref_mem[int'(addr)] : '0;
                exp_rd = (exp_rd < cmax) ? exp_rd + 1 : exp_rd;
            end
            a_access(is_wr, addr, wd, lat, rd, ms, ra);
            checks++; if (lat !== int'(A_LAT)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, lat, A_LAT); end
            checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %0h expected %0h", t, rd, exp_rdata); end
            checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rnd_pulse[%0d]: got %0h expected 0", t, ra); end
            checks++; if (a_rdc !== 16'(exp_rd) || a_wrc !== 16'(exp_wr)) begin errors++; $display("FAIL rnd_counts[%0d]: got %0d/%0d expected %0d/%0d", t, a_rdc, a_wrc, exp_rd, exp_wr); end
            checks++; if (a_err !== exp_err) begin errors++; $display("FAIL rnd_err[%0d]: got %0h expected %0h", t, a_err, exp_err); end
            if (is_wr && addr < A_DEPTH) begin
                checks++; if (ms !== wd) begin errors++; $display("FAIL rnd_wr_visible[%0d]: got %0h expected %0h", t, ms, wd); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_rd, cmax;
        do_reset();
        exp_rd = 0;
        cmax = (1 << B_CNT) - 1;
        // LATENCY+2 = 3 cycles per access: drive, wait, ready, then next drive.
        for (int i = 0; i < cmax + 2; i++) begin
            b_read = 1'b1; b_addr = 28'd2;
            @(negedge clk);
            checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL b2b_early[%0d]: got %0h expected 0", i, b_ready); end
            @(negedge clk);
            exp_rd = (exp_rd < cmax) ? exp_rd + 1 : exp_rd;
            checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0h expected 1", i, b_ready); end
            checks++; if (b_rdata !== 32'hCAFE0002) begin errors++; $display("FAIL b2b_rdata[%0d]: got %0h expected cafe0002", i, b_rdata); end
            checks++; if (b_rdc !== B_CNT'(exp_rd)) begin errors++; $display("FAIL b2b_rd_count[%0d]: got %0h expected %0h", i, b_rdc, exp_rd); end
            b_read = 1'b0;
            @(negedge clk);
            checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL b2b_pulse[%0d]: got %0h expected 0", i, b_ready); end
        end
        checks++; if (b_rdc !== 8'hFF) begin errors++; $display("FAIL b2b_saturate: got %0h expected ff", b_rdc); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %0h expected 0", b_err); end
    endtask

    initial begin
        logic [127:0] v;
        rst = 1'b0;
        a_read = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
        b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        pat_a5 = {16{8'hA5}};
        // Preload lines 0..63 of instance A and line 2 of instance B.
        for (int i = 0; i < 64; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            if (i == 3) v = pat_a5;
            if (i == 4) v = ~pat_a5;
            dut_a.mem[i] = v;
            ref_mem[i] = v;
        end
        dut_b.mem[2] = 32'hCAFE0002;
        @(negedge clk);

        test_reset();
        test_read_latency();
        test_write_read();
        test_both_error();
        test_out_of_range();
        test_mid_op_violation();
        test_random();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
